// File: rtl/arc4_sched.sv
// ARC4 datapath sequencer: runs init -> ksa -> prga once per accepted request,
// owns the single-port S memory and aborts a phase that stalls for too long.
module arc4_sched #(
    parameter int unsigned KEY_W   = 24,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic             err,
    input  logic [KEY_W-1:0] key,

    output logic             init_en,
    output logic             ksa_en,
    output logic             prga_en,
    input  logic             init_rdy,
    input  logic             ksa_rdy,
    input  logic             prga_rdy,
    output logic [KEY_W-1:0] ksa_key,
    output logic [KEY_W-1:0] prga_key,

    input  logic [7:0]       init_addr,
    input  logic [7:0]       ksa_addr,
    input  logic [7:0]       prga_addr,
    input  logic [7:0]       init_wrdata,
    input  logic [7:0]       ksa_wrdata,
    input  logic [7:0]       prga_wrdata,
    input  logic             init_wren,
    input  logic             ksa_wren,
    input  logic             prga_wren,
    output logic [7:0]       init_rddata,
    output logic [7:0]       ksa_rddata,
    output logic [7:0]       prga_rddata,

    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    input  logic [7:0]       s_rddata
);

    typedef enum logic [3:0] {
        StIdle,
        StStartInit,
        StWaitInitLo,
        StWaitInitHi,
        StStartKsa,
        StWaitKsaLo,
        StWaitKsaHi,
        StStartPrga,
        StWaitPrgaLo,
        StWaitPrgaHi,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnInit,
        OwnKsa,
        OwnPrga
    } owner_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_en_q, init_en_d;
    logic             ksa_en_q, ksa_en_d;
    logic             prga_en_q, prga_en_d;
    logic             active;
    logic             advance;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= OwnNone;
            rdy_q     <= 1'b1;
            err_q     <= 1'b0;
            key_q     <= '0;
            cnt_q     <= '0;
            init_en_q <= 1'b0;
            ksa_en_q  <= 1'b0;
            prga_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            init_en_q <= init_en_d;
            ksa_en_q  <= ksa_en_d;
            prga_en_q <= prga_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rdy_d     = rdy_q;
        err_d     = err_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        init_en_d = 1'b0;
        ksa_en_d  = 1'b0;
        prga_en_d = 1'b0;
        active    = 1'b0;
        advance   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en && rdy_q) begin
                    key_d   = key;
                    err_d   = 1'b0;
                    rdy_d   = 1'b0;
                    owner_d = OwnInit;
                    cnt_d   = '0;
                    state_d = StStartInit;
                end
            end
            StStartInit: begin
                active = 1'b1;
                if (init_rdy) begin
                    advance   = 1'b1;
                    init_en_d = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = StWaitInitLo;
                end
            end
            StWaitInitLo: begin
                active = 1'b1;
                if (!init_rdy) begin
                    advance = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = StWaitInitHi;
                end
            end
            StWaitInitHi: begin
                active = 1'b1;
                if (init_rdy) begin
                    advance = 1'b1;
                    owner_d = OwnKsa;
                    cnt_d   = '0;
                    state_d = StStartKsa;
                end
            end
            StStartKsa: begin
                active = 1'b1;
                if (ksa_rdy) begin
                    advance  = 1'b1;
                    ksa_en_d = 1'b1;
                    cnt_d    = cnt_inc;
                    state_d  = StWaitKsaLo;
                end
            end
            StWaitKsaLo: begin
                active = 1'b1;
                if (!ksa_rdy) begin
                    advance = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = StWaitKsaHi;
                end
            end
            StWaitKsaHi: begin
                active = 1'b1;
                if (ksa_rdy) begin
                    advance = 1'b1;
                    owner_d = OwnPrga;
                    cnt_d   = '0;
                    state_d = StStartPrga;
                end
            end
            StStartPrga: begin
                active = 1'b1;
                if (prga_rdy) begin
                    advance   = 1'b1;
                    prga_en_d = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = StWaitPrgaLo;
                end
            end
            StWaitPrgaLo: begin
                active = 1'b1;
                if (!prga_rdy) begin
                    advance = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = StWaitPrgaHi;
                end
            end
            StWaitPrgaHi: begin
                active = 1'b1;
                if (prga_rdy) begin
                    // Drop ownership as soon as prga reports done so late writes are not forwarded.
                    advance = 1'b1;
                    owner_d = OwnNone;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                owner_d = OwnNone;
                rdy_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A completing handshake takes priority over an expiring counter.
        if (active && !advance) begin
            if (cnt_q == TimeoutCnt) begin
                err_d   = 1'b1;
                owner_d = OwnNone;
                rdy_d   = 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (owner_q)
            OwnInit: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            OwnKsa: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            OwnPrga: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = '0;
                s_wrdata = '0;
                s_wren   = 1'b0;
            end
        endcase
    end

    assign rdy         = rdy_q;
    assign err         = err_q;
    assign init_en     = init_en_q;
    assign ksa_en      = ksa_en_q;
    assign prga_en     = prga_en_q;
    assign ksa_key     = key_q;
    assign prga_key    = key_q;
    assign init_rddata = s_rddata;
    assign ksa_rddata  = s_rddata;
    assign prga_rddata = s_rddata;

endmodule

// File: tb/tb_arc4_sched.sv
// Directed bench for arc4_sched with behavioural init/ksa/prga sub-blocks.
module tb_arc4_sched;

    localparam int KEY_W = 24;

    logic             clk = 1'b0;
    logic             rst_n, mrst_n;
    logic             en;
    logic             rdy, err;
    logic [KEY_W-1:0] key;
    logic             init_en, ksa_en, prga_en;
    logic             init_rdy, ksa_rdy, prga_rdy;
    logic [KEY_W-1:0] ksa_key, prga_key;
    logic [7:0]       init_addr, ksa_addr, prga_addr;
    logic [7:0]       init_wrdata, ksa_wrdata, prga_wrdata;
    logic             init_wren, ksa_wren, prga_wren;
    logic [7:0]       init_rddata, ksa_rddata, prga_rddata;
    logic [7:0]       s_addr, s_wrdata, s_rddata;
    logic             s_wren;

    always #5 clk = ~clk;

    arc4_sched #(
        .KEY_W  (KEY_W),
        .TIMEOUT(2000),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rdy        (rdy),
        .err        (err),
        .key        (key),
        .init_en    (init_en),
        .ksa_en     (ksa_en),
        .prga_en    (prga_en),
        .init_rdy   (init_rdy),
        .ksa_rdy    (ksa_rdy),
        .prga_rdy   (prga_rdy),
        .ksa_key    (ksa_key),
        .prga_key   (prga_key),
        .init_addr  (init_addr),
        .ksa_addr   (ksa_addr),
        .prga_addr  (prga_addr),
        .init_wrdata(init_wrdata),
        .ksa_wrdata (ksa_wrdata),
        .prga_wrdata(prga_wrdata),
        .init_wren  (init_wren),
        .ksa_wren   (ksa_wren),
        .prga_wren  (prga_wren),
        .init_rddata(init_rddata),
        .ksa_rddata (ksa_rddata),
        .prga_rddata(prga_rddata),
        .s_addr     (s_addr),
        .s_wrdata   (s_wrdata),
        .s_wren     (s_wren),
        .s_rddata   (s_rddata)
    );

    // Sub-block models: index 0 init, 1 ksa, 2 prga. They have their own reset so a DUT
    // reset mid-run leaves a busy sub-block still writing.
    int   dur [3] = '{256, 1280, 600};
    int   lo_dly;
    logic rdy_m [3];
    int   lo_c [3];
    int   busy_c [3];
    logic inject, inject_all, ksa_stuck;
    logic [2:0] en_v;

    assign en_v = {prga_en, ksa_en, init_en};

    always @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            for (int i = 0; i < 3; i++) begin
                rdy_m[i]  <= 1'b1;
                lo_c[i]   <= 0;
                busy_c[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (en_v[i]) begin
                    lo_c[i]   <= lo_dly;
                    busy_c[i] <= dur[i];
                end else if (lo_c[i] > 0) begin
                    lo_c[i] <= lo_c[i] - 1;
                    if (lo_c[i] == 1) rdy_m[i] <= 1'b0;
                end else if (!rdy_m[i]) begin
                    busy_c[i] <= busy_c[i] - 1;
                    if (busy_c[i] == 1) rdy_m[i] <= 1'b1;
                end
            end
        end
    end

    assign init_rdy    = rdy_m[0];
    assign ksa_rdy     = rdy_m[1] & ~ksa_stuck;
    assign prga_rdy    = rdy_m[2];
    assign init_wren   = inject | inject_all | ~rdy_m[0];
    assign init_addr   = (inject | inject_all) ? 8'hAA : {1'b1, 7'(busy_c[0])};
    assign init_wrdata = 8'(busy_c[0]);
    assign ksa_wren    = inject_all | ~rdy_m[1];
    assign ksa_addr    = inject_all ? 8'hAA : ksa_stuck ? 8'h5A : {1'b0, 7'(busy_c[1])};
    assign ksa_wrdata  = 8'(busy_c[1]);
    assign prga_wren   = inject | inject_all | ~rdy_m[2];
    assign prga_addr   = (inject | inject_all) ? 8'hAA : {1'b1, 7'(busy_c[2])};
    assign prga_wrdata = 8'(busy_c[2]);

    // Start-pulse monitor
    int         pulse_log[$];
    int         dup_cnt, overlap_cnt, key_bad;
    logic       key_watch;
    logic [2:0] en_prev = 3'b000;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (en_v[i]) begin
                pulse_log.push_back(i);
                if (en_prev[i]) dup_cnt++;
            end
        end
        if ($countones(en_v) > 1) overlap_cnt++;
        if (key_watch && ksa_key !== 24'h123456) key_bad++;
        en_prev = en_v;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur(input int idx);
        case (idx)
            0:       return init_rdy;
            1:       return ksa_rdy;
            2:       return prga_rdy;
            3:       return rdy;
            default: return s_addr == 8'h5A;
        endcase
    endfunction

    task automatic wait_for(input int idx, input logic val, input int budget, input string tag);
        int n = 0;
        while (cur(idx) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, cur(idx), val);
    endtask

    task automatic clear_mon();
        pulse_log.delete();
        dup_cnt     = 0;
        overlap_cnt = 0;
    endtask

    task automatic start_run(input logic [KEY_W-1:0] k);
        @(negedge clk);
        en  = 1'b1;
        key = k;
        @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic check_run(input string tag);
        check({tag, "_npulse"}, pulse_log.size(), 3);
        if (pulse_log.size() == 3)
            for (int i = 0; i < 3; i++) check({tag, "_order"}, pulse_log[i], i);
        check({tag, "_dup"}, dup_cnt, 0);
        check({tag, "_overlap"}, overlap_cnt, 0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_rdy"}, rdy, 1'b1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"}, rdy, 1'b1);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_wren"}, s_wren, 1'b0);
        check({tag, "_addr"}, s_addr, 8'h00);
        check({tag, "_en"}, en_v, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        en = 1'b0; key = '0; inject = 1'b0; inject_all = 1'b0; ksa_stuck = 1'b0;
        lo_dly = 1; key_watch = 1'b0; key_bad = 0; dup_cnt = 0; overlap_cnt = 0;
        s_rddata = 8'h3C;
        rst_n = 1'b0; mrst_n = 1'b0;

        // Reset state, held and released
        #12;
        check_quiet("rst_hold");
        @(negedge clk);
        rst_n = 1'b1; mrst_n = 1'b1;
        @(negedge clk);
        check_quiet("rst_rel");
        check("rddata_fanout", {init_rddata, ksa_rddata, prga_rddata}, 24'h3C3C3C);

        // Normal run
        clear_mon();
        start_run(24'h000018);
        check("run1_busy", rdy, 1'b0);
        wait_for(3, 1'b1, 5000, "run1_done");
        check_run("run1");
        check("run1_ksa_key", ksa_key, 24'h000018);
        check("run1_prga_key", prga_key, 24'h000018);

        // Ownership: only ksa reaches the memory during its phase
        clear_mon();
        start_run(24'h00A5A5);
        wait_for(1, 1'b0, 2000, "own_ksa_busy");
        inject = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("own_wren", s_wren, 1'b1);
            check("own_addr", s_addr, {1'b0, 7'(busy_c[1])});
        end
        inject = 1'b0;
        wait_for(3, 1'b1, 5000, "own_done");
        check_run("own");
        inject_all = 1'b1;
        @(negedge clk);
        check("idle_wren", s_wren, 1'b0);
        check("idle_addr", s_addr, 8'h00);
        inject_all = 1'b0;

        // Timeout in ksa: abort lands on the 2001st edge after START_KSA entry (cnt 0..2000)
        clear_mon();
        ksa_stuck = 1'b1;
        start_run(24'h000777);
        wait_for(4, 1'b1, 1000, "to_ksa_owned");
        repeat (2000) @(posedge clk);
        #1;
        check("to_early_rdy", rdy, 1'b0);
        check("to_early_err", err, 1'b0);
        @(posedge clk);
        #1;
        check("to_rdy", rdy, 1'b1);
        check("to_err", err, 1'b1);
        check("to_owner_none", s_addr, 8'h00);
        check("to_npulse", pulse_log.size(), 1);
        ksa_stuck = 1'b0;
        clear_mon();
        start_run(24'h000042);
        check("to_err_clr", err, 1'b0);
        wait_for(3, 1'b1, 5000, "to_rerun_done");
        check_run("to_rerun");

        // Requests while busy are ignored; slow rdy drop gives no duplicate pulse
        lo_dly = 3;
        clear_mon();
        start_run(24'h123456);
        key_bad = 0;
        key_watch = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            en  = 1'b1;
            key = 24'hFFFFFF;
            @(negedge clk);
            if (rdy) break;
        end
        en = 1'b0;
        key_watch = 1'b0;
        check("busy_done", rdy, 1'b1);
        check("busy_key_held", key_bad, 0);
        check("busy_ksa_key", ksa_key, 24'h123456);
        check_run("busy");
        @(negedge clk);
        check("busy_not_reaccepted", rdy, 1'b1);
        lo_dly = 1;

        // Asynchronous reset in the middle of prga
        clear_mon();
        start_run(24'h0000C3);
        wait_for(2, 1'b0, 5000, "mid_prga_busy");
        @(negedge clk);
        check("mid_pre_wren", s_wren, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_wren", s_wren, 1'b0);
        check("mid_addr", s_addr, 8'h00);
        check("mid_rdy", rdy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        start_run(24'h00BEEF);
        wait_for(3, 1'b1, 5000, "post_rst_done");
        check_run("post_rst");
        check("post_rst_key", prga_key, 24'h00BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
